irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Memory-mapped interrupt arbiter between the timer/peripheral IRQ lines and the CPU's CP0 interrupt input. Latches up to `N_SRC` interrupt requests (level or edge per source), masks them, selects one winner, and runs a claim/complete handshake so exactly one source is in service at a time. Sits on the system bridge next to the timers and is accessed through the same word-addressed load/store path.

## Interface
- `N_SRC`, 6: number of interrupt sources. Range 1..31. Source `i` has id `i+1`; id 0 means "none".
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `addr`  in  30 (`[31:2]`)  word address; only `addr[4:2]` decoded.
- `we`  in  1  write strobe for the selected register.
- `re`  in  1  read strobe; needed only for the CLAIM side effect.
- `din`  in  32  write data.
- `dout`  out  32  combinational read data of the selected register.
- `src_irq`  in  N_SRC  raw requests; bit 0 is TC0, bit 1 is TC1.
- `irq`  out  1  registered interrupt request to CP0.
- `irq_id`  out  5  registered id of the current winner; 0 when `irq`=0.

## Operation
- Registers, by `addr[4:2]`:
  - 0 CTRL: bit0 GEN (global enable); other bits read 0.
  - 1 MASK: bit i enables source i.
  - 2 TRIG: bit i=1 edge, 0 level.
  - 3 PEND: read gives pending; write-1-to-clear, edge sources only.
  - 4 CLAIM: read claims, write completes.
  - Codes 5..7 read 0; writes to them are ignored.
  - Bits at and above N_SRC read 0 and are not writable.
- Sampling: `src_q <= src_irq` every cycle.
  - Edge source: `pend[i]` is set on `src_irq[i] & ~src_q[i]`.
  - Level source: `pend[i] = src_q[i]`, and W1C has no effect on it.
- Eligible set: `pend & MASK & ~insvc`, gated by GEN.
- Winner: lowest eligible index (fixed priority).
- FSM states:
  - IDLE: no eligible source. Moves to ASSERT when the eligible set is non-empty.
  - ASSERT: `irq`=1 and `irq_id`=winner. If the eligible set empties before a claim (mask or W1C), return to IDLE with `irq`=0.
  - A CLAIM read (`re` with addr 3'd4) moves ASSERT to SERVICE.
  - SERVICE: `irq`=0. On a write to CLAIM with `din[4:0]` equal to the in-service id, clear `insvc` and return to IDLE. A write with any other id is ignored.
- CLAIM read behaviour:
  - In ASSERT: `dout` = the current winner id. At the edge, set `insvc` to that id and clear the edge-source `pend` bit.
  - In IDLE or SERVICE: returns 0 with no side effect.
- Simultaneous events:
  - A new edge wins over W1C of the same bit in the same cycle (bit stays set).
  - A new edge on the in-service source re-pends it. It is not eligible until completed.
  - Clearing GEN in SERVICE does not cancel service; completion is still required.
- Reset, at any time including mid-service:
  - CTRL, MASK, TRIG, PEND, `insvc`, `src_q` are all 0.
  - State is IDLE; `irq`=0, `irq_id`=0.

## Timing
- `src_irq` rising at edge k is seen by `src_q` at k+1. The pend bit is set at k+1 for edge sources and follows `src_q` for level sources.
- `irq` rises at k+2, so source-to-`irq` latency is 2 cycles.
- Register writes take effect at the clock edge. A MASK or GEN clear drops `irq` one cycle later.
- CLAIM read: `dout` is valid in the same cycle. `irq` is 0 from the next edge.
- After a completing write, a still-eligible source re-asserts `irq` 1 cycle later, passing through IDLE to ASSERT.

## Configuration
- `IRQ_ARB_ROUND_ROBIN_EN` defined:
  - Winner is the first eligible index above the last claimed id, wrapping around.
  - The last-claimed pointer resets to N_SRC-1, so source 0 wins first.
- `IRQ_ARB_ROUND_ROBIN_EN` undefined: fixed lowest-index priority, with no pointer register.

## Structure
- A shared package holds:
  - register offset constants `IRQ_CTRL`/`IRQ_MASK`/`IRQ_TRIG`/`IRQ_PEND`/`IRQ_CLAIM`;
  - FSM state encoding `IRQ_IDLE`/`IRQ_ASSERT`/`IRQ_SERVICE`;
  - `IRQ_ID_NONE` = 0.
- One sub-module, `irq_prio_sel`: combinational eligible-vector to winner id, with an optional rotate base.

## Test plan
- Edge priority: TRIG=0x3F, MASK=0x3F, GEN=1; pulse src bits 0 and 2 together. `irq`=1 with `irq_id`=1 after 2 cycles. CLAIM read returns 1. Write 1 to CLAIM; `irq` returns with `irq_id`=3.
- Level source: TRIG=0, MASK=0x02; hold src bit 1 high. CLAIM returns 2. After completion with src still high, the source re-asserts. Dropping src before the claim returns the FSM to IDLE and CLAIM reads 0.
- Masking and GEN: source pending with MASK=0, so `irq` stays 0. Set MASK; `irq`=1 one cycle later. Clear GEN in ASSERT; `irq`=0 next cycle.
- Bad completion: in SERVICE with id 3, write 5 to CLAIM. State stays SERVICE and `irq` stays 0. Writing 3 then completes.
- W1C race: an edge on bit 4 in the same cycle as writing PEND=0x10 leaves PEND bit 4 at 1.
- Reset mid-service: assert `reset` in SERVICE. All registers read 0, `irq`=0, and the next CLAIM returns 0. With RR enabled, alternating pulses on sources 0 and 1 are claimed as 1, 2, 1, 2.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: register offsets, FSM encoding, null id.
package irq_arbiter_pkg;

  localparam logic [2:0] IRQ_CTRL  = 3'd0;
  localparam logic [2:0] IRQ_MASK  = 3'd1;
  localparam logic [2:0] IRQ_TRIG  = 3'd2;
  localparam logic [2:0] IRQ_PEND  = 3'd3;
  localparam logic [2:0] IRQ_CLAIM = 3'd4;

  localparam logic [4:0] IRQ_ID_NONE = 5'd0;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner select: first eligible index above base_i, else lowest eligible index.
module irq_prio_sel
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] elig_i,
  input  logic [4:0]       base_i,
  output logic [4:0]       id_o,
  output logic             valid_o
);

  logic       hi_hit;
  logic [4:0] hi_id;
  logic [4:0] lo_id;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    hi_hit = 1'b0;
    hi_id  = IRQ_ID_NONE;
    lo_id  = IRQ_ID_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        lo_id = 5'(i + 1);
        if (5'(i) > base_i) begin
          hi_id  = 5'(i + 1);
          hi_hit = 1'b1;
        end
      end
    end
    valid_o = |elig_i;
    id_o    = hi_hit ? hi_id : lo_id;
  end

endmodule

// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt arbiter with claim/complete handshake toward CP0.
// Define IRQ_ARB_ROUND_ROBIN_EN for round-robin winner selection instead of fixed priority.
//
// state       | meaning
// IRQ_IDLE    | no eligible source, irq low
// IRQ_ASSERT  | irq high with current winner id, waiting for a CLAIM read
// IRQ_SERVICE | one source claimed, waiting for a matching CLAIM write
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  input  logic [N_SRC-1:0] src_irq,
  output logic             irq,
  output logic [4:0]       irq_id
);

  logic [2:0]       reg_sel;
  logic             gen_q, gen_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] trig_q, trig_d;
  logic [N_SRC-1:0] epend_q, epend_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend, elig, insvc_vec, edge_set, w1c, claim_clr;
  logic [4:0]       insvc_q, insvc_d;
  logic [4:0]       win_id, rr_base;
  logic             win_valid, claim_rd, claim_take, cmpl_ok;
  irq_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic [4:0]       irq_id_q, irq_id_d;
  logic             unused_bits;

  assign reg_sel     = addr[4:2];
  assign unused_bits = ^{addr[31:5], din};

  assign claim_rd   = re && (reg_sel == IRQ_CLAIM);
  assign claim_take = claim_rd && (state_q == IRQ_ASSERT) && win_valid;
  assign cmpl_ok    = we && (reg_sel == IRQ_CLAIM) && (state_q == IRQ_SERVICE)
                      && (din[4:0] == insvc_q);

  always_comb begin
    insvc_vec = '0;
    claim_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      insvc_vec[i] = (insvc_q == 5'(i + 1));
      claim_clr[i] = claim_take && (win_id == 5'(i + 1));
    end
  end

  // Level sources follow the sampled line; only edge sources hold a latched bit.
  assign pend     = (trig_q & epend_q) | (~trig_q & src_q);
  assign elig     = {N_SRC{gen_q}} & pend & mask_q & ~insvc_vec;
  assign edge_set = src_irq & ~src_q & trig_q;
  assign w1c      = {N_SRC{we && (reg_sel == IRQ_PEND)}} & din[N_SRC-1:0] & trig_q;

  irq_prio_sel #(.N_SRC(N_SRC)) u_prio_sel (
    .elig_i (elig),
    .base_i (rr_base),
    .id_o   (win_id),
    .valid_o(win_valid)
  );

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [4:0] ptr_q, ptr_d;

  assign rr_base = ptr_q;
  assign ptr_d   = claim_take ? (win_id - 5'd1) : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 5'(N_SRC - 1);
    else       ptr_q <= ptr_d;
  end
`else
  assign rr_base = 5'(N_SRC - 1);
`endif

  always_comb begin
    gen_d  = gen_q;
    mask_d = mask_q;
    trig_d = trig_q;
    if (we) begin
      case (reg_sel)
        IRQ_CTRL: gen_d  = din[0];
        IRQ_MASK: mask_d = din[N_SRC-1:0];
        IRQ_TRIG: trig_d = din[N_SRC-1:0];
        default:  ;
      endcase
    end
    // A fresh edge outranks both W1C and the claim clear of the same bit.
    epend_d = ((epend_q & ~w1c & ~claim_clr) | edge_set) & trig_q;
  end

  always_comb begin
    state_d = state_q;
    insvc_d = insvc_q;
    case (state_q)
      IRQ_IDLE: if (win_valid) state_d = IRQ_ASSERT;
      IRQ_ASSERT: begin
        if (claim_take) begin
          state_d = IRQ_SERVICE;
          insvc_d = win_id;
        end else if (!win_valid) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SERVICE: begin
        if (cmpl_ok) begin
          state_d = IRQ_IDLE;
          insvc_d = IRQ_ID_NONE;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
    irq_d    = (state_d == IRQ_ASSERT);
    irq_id_d = irq_d ? win_id : IRQ_ID_NONE;
  end

  always_comb begin
    dout = '0;
    case (reg_sel)
      IRQ_CTRL:  dout = {31'd0, gen_q};
      IRQ_MASK:  dout = 32'(mask_q);
      IRQ_TRIG:  dout = 32'(trig_q);
      IRQ_PEND:  dout = 32'(pend);
      IRQ_CLAIM: if (state_q == IRQ_ASSERT) dout = 32'(win_id);
      default:   dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_q    <= 1'b0;
      mask_q   <= '0;
      trig_q   <= '0;
      epend_q  <= '0;
      src_q    <= '0;
      insvc_q  <= IRQ_ID_NONE;
      state_q  <= IRQ_IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= IRQ_ID_NONE;
    end else begin
      gen_q    <= gen_d;
      mask_q   <= mask_d;
      trig_q   <= trig_d;
      epend_q  <= epend_d;
      src_q    <= src_irq;
      insvc_q  <= insvc_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: stimulus queues expected reads/irq samples, a monitor checks them.
module tb_irq_arbiter;

  localparam int N = 6;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:2]   addr = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic          chk = 1'b0;
  logic [31:0]   din = '0;
  logic [31:0]   dout;
  logic [N-1:0]  src_irq = '0;
  logic          irq;
  logic [4:0]    irq_id;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .re     (re),
    .din    (din),
    .dout   (dout),
    .src_irq(src_irq),
    .irq    (irq),
    .irq_id (irq_id)
  );

  // Monitor: a read or an irq sample strobe is the DUT presenting a response.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (re || chk) begin
      n_tot++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: got a response 0x%08h, want a queued expectation", dout);
      end else begin
        e   = sb.pop_front();
        act = e.is_irq ? {26'd0, irq, irq_id} : dout;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    addr = 30'(sel);
    din  = data;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, input logic [31:0] exp_v, input string nm);
    exp_t e;
    e.name = nm;
    e.is_irq = 1'b0;
    e.val = exp_v;
    sb.push_back(e);
    addr = 30'(sel);
    re   = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  task automatic ei(input logic exp_irq, input logic [4:0] exp_id, input string nm);
    exp_t e;
    e.name = nm;
    e.is_irq = 1'b1;
    e.val = {26'd0, exp_irq, exp_id};
    sb.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end within time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [4:0] second;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    rd(3'd0, 32'h0, "rst_ctrl");
    rd(3'd1, 32'h0, "rst_mask");
    rd(3'd2, 32'h0, "rst_trig");
    rd(3'd3, 32'h0, "rst_pend");
    ei(1'b0, 5'd0, "rst_irq");
    rd(3'd4, 32'h0, "rst_claim");
    rd(3'd6, 32'h0, "unmapped_rd");

    // edge priority
    wr(3'd2, 32'h3F);
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, 32'h3F, "mask_width");
    wr(3'd0, 32'h1);
    src_irq = 6'b000101; idle(1);
    src_irq = '0;        ei(1'b0, 5'd0, "edge_lat1");
    ei(1'b1, 5'd1, "edge_irq");
    rd(3'd4, 32'd1, "edge_claim");
    ei(1'b0, 5'd0, "svc_irq0");
    wr(3'd4, 32'd1);
    idle(1);
    ei(1'b1, 5'd3, "edge_next");
    rd(3'd4, 32'd3, "edge_claim3");

    // bad completion while id 3 is in service
    src_irq = 6'b000001; wr(3'd4, 32'd5);
    src_irq = '0;        idle(1);
    ei(1'b0, 5'd0, "bad_cmpl_irq");
    rd(3'd4, 32'd0, "bad_cmpl_claim");
    wr(3'd4, 32'd3);
    idle(1);
    ei(1'b1, 5'd1, "good_cmpl_irq");
    rd(3'd4, 32'd1, "good_cmpl_claim");
    wr(3'd4, 32'd1);

    // W1C race on bit 4
    wr(3'd0, 32'h0);
    src_irq = 6'b010000; wr(3'd3, 32'h10);
    src_irq = '0;        rd(3'd3, 32'h10, "w1c_race");
    wr(3'd3, 32'h10);
    rd(3'd3, 32'h0, "w1c_clear");

    // masking and GEN
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h1);
    src_irq = 6'b001000; idle(1);
    src_irq = '0;        idle(1);
    ei(1'b0, 5'd0, "masked_irq");
    rd(3'd3, 32'h08, "masked_pend");
    wr(3'd1, 32'h3F);
    ei(1'b0, 5'd0, "unmask_lat");
    ei(1'b1, 5'd4, "unmask_irq");
    wr(3'd0, 32'h0);
    ei(1'b1, 5'd4, "gen_clr_lat");
    ei(1'b0, 5'd0, "gen_clr_irq");
    wr(3'd3, 32'h08);

    // level source
    wr(3'd0, 32'h1);
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h02);
    src_irq = 6'b000010; idle(1);
    idle(1);
    ei(1'b1, 5'd2, "lvl_irq");
    rd(3'd3, 32'h02, "lvl_pend");
    wr(3'd3, 32'h02);
    rd(3'd3, 32'h02, "lvl_w1c_noeff");
    rd(3'd4, 32'd2, "lvl_claim");
    ei(1'b0, 5'd0, "lvl_svc_irq");
    wr(3'd4, 32'd2);
    idle(1);
    ei(1'b1, 5'd2, "lvl_reassert");
    src_irq = '0; idle(1);
    idle(1);
    rd(3'd4, 32'd0, "lvl_drop_claim");
    ei(1'b0, 5'd0, "lvl_drop_irq");

    // reset mid-service
    wr(3'd2, 32'h3F);
    wr(3'd1, 32'h3F);
    src_irq = 6'b100000; idle(1);
    src_irq = '0;        idle(1);
    rd(3'd4, 32'd6, "pre_rst_claim");
    src_irq = 6'b000001; idle(1);
    src_irq = '0; reset = 1'b1; idle(1);
    reset = 1'b0;
    rd(3'd0, 32'h0, "rst2_ctrl");
    rd(3'd1, 32'h0, "rst2_mask");
    rd(3'd2, 32'h0, "rst2_trig");
    rd(3'd3, 32'h0, "rst2_pend");
    ei(1'b0, 5'd0, "rst2_irq");
    rd(3'd4, 32'd0, "rst2_claim");

    // alternating sources 0 and 1
    wr(3'd2, 32'h3F);
    wr(3'd1, 32'h3F);
    wr(3'd0, 32'h1);
    for (int j = 0; j < 4; j++) begin
      src_irq = 6'(1 << (j % 2)); idle(1);
      src_irq = '0;               idle(1);
      rd(3'd4, 32'((j % 2) + 1), $sformatf("alt_claim%0d", j));
      wr(3'd4, 32'((j % 2) + 1));
    end

    // both pending after claiming source 0: round-robin picks source 1 next
    src_irq = 6'b000011; idle(1);
    src_irq = '0;        idle(1);
    rd(3'd4, 32'd1, "pair_first");
    src_irq = 6'b000001; wr(3'd4, 32'd1);
    src_irq = '0;        idle(1);
    second = RR ? 5'd2 : 5'd1;
    rd(3'd4, 32'(second), "pair_second");
    wr(3'd4, 32'(second));
    idle(1);
    rd(3'd4, 32'(RR ? 5'd1 : 5'd2), "pair_third");
    wr(3'd4, 32'(RR ? 5'd1 : 5'd2));
    idle(2);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tot++;
      $display("FAIL %s: got no response, want 0x%08h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
